gray_code_stream_conv: RTL
==========================

Name: gray_code_stream_conv

Overview:
- Parametrised, registered successor to the team's 4-bit combinational Gray-to-binary converter.
- Converts a stream of WIDTH-bit words in either direction, selected per word: Gray->binary or binary->Gray.
- Uses a valid/ready handshake on both sides and a 2-entry output buffer to absorb backpressure.
- Sits between producer/consumer datapaths, e.g. as a stage in pointer synchronisation or encoder pipelines.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept a word this cycle.
- in_mode  input  1  0 = Gray->binary, 1 = binary->Gray; qualified by in_valid.
- in_data  input  WIDTH  word to convert.
- out_valid  output  1  out_data/out_mode hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode the word was converted with.
- xfer_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Conversion is applied before storage; there is no arithmetic carry.
  - Gray->binary: B[WIDTH-1]=G[WIDTH-1]; B[i]=B[i+1]^G[i] for i=WIDTH-2..0.
  - Binary->Gray: G = B ^ (B>>1), with a logical shift.
- Buffer: 2-entry FIFO of {mode, converted data}, with occupancy count in 0..2.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = rst_n && (count != 2). in_ready has no combinational dependence on out_ready.
- out_valid = (count != 0). out_data and out_mode always present the oldest entry. They are stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears on out_data after edge N, provided the buffer was empty. Otherwise it appears once the older entry is popped. Order is strictly FIFO.
- Simultaneous push and pop:
  - count=1: count stays 1; the head becomes the new word after the edge.
  - count=2: in_ready=0, so a pop only.
- Push when full is impossible by construction. Input held with in_valid=1 while in_ready=0 is not consumed.
- xfer_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Reset, applied when rst_n=0 at a rising edge:
  - count=0, out_valid=0, out_data=0, out_mode=0, xfer_cnt=0.
  - in_ready=0 while rst_n is low; in_ready=1 on the first cycle after release.
- Reset mid-operation discards all buffered entries. A handshake in the same cycle as reset is ignored.
- in_mode and in_data are don't-care when in_valid=0. X on them must not propagate into state.
- Buffer storage is not required to be cleared except the head output, which is forced to 0 when count=0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_data=0, xfer_cnt=0, in_ready=0 during reset and 1 after.
- Gray->binary, WIDTH=4, out_ready=1: stream in_mode=0 with 0000, 0001, 0011, 0010, 0110, 1011, 1000 -> out_data 0000, 0001, 0010, 0011, 0100, 1101, 1111, each one cycle after acceptance; xfer_cnt=7.
- Binary->Gray, WIDTH=4: in_mode=1 with 1101 -> out_data 1011, out_mode=1. Round trip: feed 1011 with mode 0 -> 1101. Exhaustive 0..15 both directions must match the formulas.
- Backpressure: out_ready=0, offer 0011, 0110, 1111 in mode 0 -> first two accepted, in_ready=0 on the third. out_data holds 0010 stable. Raise out_ready -> outputs 0010, 0100, then 1010 in order; no loss or duplication.
- Simultaneous push/pop at count=1 -> count stays 1, head advances to the new word. Reset pulse with 2 entries buffered -> next cycle out_valid=0 and the buffer is empty.
- WIDTH=8, CNT_W=4:
  - Gray 10000000 -> binary 11111111.
  - 17 completed transfers -> xfer_cnt wraps through 0 and reads 1.

Source files
------------

// File: rtl/gray_code_stream_conv.sv
// Streaming Gray<->binary converter with valid/ready handshakes on both sides.
// Words are converted on entry and held in a 2-entry FIFO to absorb consumer backpressure.
module gray_code_stream_conv #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned Depth = 2;

  // Each entry is {mode, converted data}
  logic [WIDTH:0]       mem_q [Depth];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [CNT_W-1:0]     xfer_cnt_q, xfer_cnt_d;

  logic                 push;
  logic                 pop;
  logic [WIDTH-1:0]     g2b;
  logic [WIDTH-1:0]     b2g;
  logic [WIDTH-1:0]     conv_data;
  logic [WIDTH:0]       head;

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    g2b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      g2b[i] = ^(in_data >> i);
    end
  end

  assign b2g       = in_data ^ (in_data >> 1);
  assign conv_data = in_mode ? b2g : g2b;

  // in_ready depends only on rst_n and occupancy, never on out_ready.
  assign in_ready  = rst_n && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      xfer_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Storage is written only on a qualified push, so idle-bus X never enters state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_mode, conv_data};
    end
  end

  // Head is forced to zero when empty, hiding stale or uninitialised storage.
  assign head     = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign out_data = head[WIDTH-1:0];
  assign out_mode = head[WIDTH];
  assign xfer_cnt = xfer_cnt_q;

endmodule
